// File: rtl/uart_pkg.sv
// Shared definitions for the UART result transmitter: FSM encodings, frame
// constants and the response-frame byte helpers.
package uart_pkg;

  localparam int unsigned FRAME_BYTES          = 5;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [7:0]  DEFAULT_HEADER       = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStartBit, StDataBits, StStopBit} bit_state_e;
  typedef enum logic [1:0] {TopIdle, TopSend, TopNextByte} top_state_e;

  function automatic logic [7:0] frame_checksum(logic [7:0] hdr, logic [2:0] op,
                                                logic [15:0] res);
    return hdr ^ {5'b0, op} ^ res[15:8] ^ res[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(logic [2:0] idx, logic [7:0] hdr, logic [2:0] op,
                                            logic [15:0] res, logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = {5'b0, op};
      3'd2:    b = res[15:8];
      3'd3:    b = res[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Request/response bundle between the ALU side and the UART result transmitter.
interface uart_result_tx_if;
  logic        start;
  logic [15:0] result;
  logic [2:0]  opcode;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, result, opcode, input tx, busy, done);
  modport slave  (input start, result, opcode, output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. tx_done_o is high in the final cycle of the
// stop bit so the caller can chain the next byte with a single-cycle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int unsigned    CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  bit_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    tx_d      = tx_q;
    tx_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          state_d = StStartBit;
          cnt_d   = '0;
          data_d  = data_i;
          tx_d    = 1'b0;
        end
      end
      StStartBit: begin
        if (bit_end) begin
          state_d = StDataBits;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDataBits: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStopBit;
            tx_d    = 1'b1;
          end else begin
            // Shift register keeps the current bit at data_q[0].
            bit_d  = bit_q + 3'd1;
            data_d = {1'b0, data_q[7:1]};
            tx_d   = data_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStopBit: begin
        if (bit_end) begin
          state_d   = StIdle;
          cnt_d     = '0;
          tx_done_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: rtl/uart_result_tx.sv
// Captures an ALU result/opcode on start and sends the 5-byte response frame
// (header, opcode, result hi, result lo, XOR checksum) over UART 8N1.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0]  HEADER       = DEFAULT_HEADER
) (
  input  logic             clock,
  input  logic             reset,
  uart_result_tx_if.slave  bus
);

  top_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [7:0]  chk_q, chk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_tx;
  logic        byte_busy;
  logic        byte_done;

  // The done cycle is still the tail of the old frame, so start is refused then.
  assign accept     = (state_q == TopIdle) && bus.start && !done_q && !byte_busy;
  assign byte_valid = accept || (state_q == TopNextByte);
  // idx_q is 0 while idle, so the header is presented on the accept cycle itself.
  assign byte_data  = frame_byte(idx_q, HEADER, opcode_q, result_q, chk_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    opcode_d = opcode_q;
    chk_d    = chk_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      TopIdle: begin
        if (accept) begin
          state_d  = TopSend;
          idx_d    = '0;
          result_d = bus.result;
          opcode_d = bus.opcode;
          chk_d    = frame_checksum(HEADER, bus.opcode, bus.result);
          busy_d   = 1'b1;
        end
      end
      TopSend: begin
        if (byte_done) begin
          if (idx_q == 3'(FRAME_BYTES - 1)) begin
            state_d = TopIdle;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = TopNextByte;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      TopNextByte: state_d = TopSend;
      default:     state_d = TopIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= TopIdle;
      idx_q    <= '0;
      result_q <= '0;
      opcode_q <= '0;
      chk_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      opcode_q <= opcode_d;
      chk_q    <= chk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i     (clock),
    .rst_ni    (reset),
    .valid_i   (byte_valid),
    .data_i    (byte_data),
    .tx_o      (byte_tx),
    .busy_o    (byte_busy),
    .tx_done_o (byte_done)
  );

  assign bus.tx   = byte_tx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx at 4 clocks per bit: frame contents,
// timing, start filtering, async reset and back-to-back frames.
module tb_uart_result_tx;

  localparam int C    = 4;
  localparam int BYTE = 10 * C + 1;   // byte period including the inter-byte gap
  localparam int LOGN = 420;

  logic clock;
  logic reset;
  uart_result_tx_if bus ();

  uart_result_tx #(
    .CLKS_PER_BIT (C),
    .HEADER       (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors;
  int   checks;
  logic tx_log   [0:LOGN-1];
  logic busy_log [0:LOGN-1];
  logic done_log [0:LOGN-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [15:0] res, input logic [2:0] op);
    bus.start  = 1'b1;
    bus.result = res;
    bus.opcode = op;
    step();
    bus.start = 1'b0;
  endtask

  // Log index n is the cycle n after the accept edge; inputs set here apply to that cycle.
  task automatic run(input int ncyc, input bit scramble, input bit poke, input int s,
                     input logic [15:0] nres, input logic [2:0] nop);
    for (int n = 0; n < ncyc; n++) begin
      tx_log[n]   = bus.tx;
      busy_log[n] = bus.busy;
      done_log[n] = bus.done;
      bus.start   = 1'b0;
      if (scramble) begin
        bus.result = n[0] ? 16'hFFFF : 16'h0000;
        bus.opcode = n[0] ? 3'b111 : 3'b000;
      end
      if (poke && (n == 10 || n == 100 || n == 203 || n == 204)) bus.start = 1'b1;
      if (n == s) begin
        bus.start  = 1'b1;
        bus.result = nres;
        bus.opcode = nop;
      end
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base, input logic [39:0] exp);
    for (int k = 0; k < 5; k++) begin
      int         st;
      logic [7:0] b;
      logic       ok;
      st = base + k * BYTE;
      for (int j = 0; j < 8; j++) b[j] = tx_log[st + (j + 1) * C + C / 2];
      ok = (tx_log[st] === 1'b0) && (tx_log[st + C - 1] === 1'b0);
      for (int c = 9 * C; c < 10 * C; c++) ok = ok && (tx_log[st + c] === 1'b1);
      if (k < 4) ok = ok && (tx_log[st + 10 * C] === 1'b1);
      chk($sformatf("%s_byte%0d", tag, k), {24'h0, b}, {24'h0, exp[39 - 8 * k -: 8]});
      chk($sformatf("%s_framing%0d", tag, k), {31'h0, ok}, 32'h1);
    end
  endtask

  function automatic int count_done(input int lo, input int hi);
    int cnt;
    cnt = 0;
    for (int i = lo; i <= hi; i++) if (done_log[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  initial begin
    int bad;
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.result = '0;
    bus.opcode = '0;

    // 1: reset and idle line
    repeat (3) step();
    chk("reset_outputs", {29'h0, bus.tx, bus.busy, bus.done}, 32'h4);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_line", {29'h0, bus.tx, bus.busy, bus.done}, 32'h4);
    end

    // 2: basic frame and its timing
    accept(16'h1234, 3'b010);
    run(210, 1'b0, 1'b0, -1, '0, '0);
    check_frame("basic", 0, 40'hA5_02_12_34_81);
    chk("latency_tx_low", {31'h0, tx_log[0]}, 32'h0);
    chk("busy_first", {31'h0, busy_log[0]}, 32'h1);
    chk("busy_last", {31'h0, busy_log[203]}, 32'h1);
    chk("busy_drop", {31'h0, busy_log[204]}, 32'h0);
    chk("done_at_204", {31'h0, done_log[204]}, 32'h1);
    chk("done_once", count_done(0, 209), 32'd1);
    chk("idle_after", {31'h0, tx_log[209]}, 32'h1);

    // 3: inputs changing during the frame
    accept(16'h1234, 3'b010);
    run(210, 1'b1, 1'b0, -1, '0, '0);
    check_frame("stable", 0, 40'hA5_02_12_34_81);

    // 4: start while busy and in the done cycle is dropped; 205 is accepted
    accept(16'h1234, 3'b010);
    run(412, 1'b0, 1'b1, 205, 16'hBEEF, 3'b101);
    check_frame("poke_f1", 0, 40'hA5_02_12_34_81);
    chk("poke_done_once", count_done(0, 205), 32'd1);
    chk("poke_done_at_204", {31'h0, done_log[204]}, 32'h1);
    chk("poke_idle_205", {30'h0, tx_log[205], busy_log[205]}, 32'h2);
    chk("poke_second_tx", {31'h0, tx_log[206]}, 32'h0);
    check_frame("poke_f2", 206, 40'hA5_05_BE_EF_F1);
    chk("poke_f2_done", {31'h0, done_log[206 + 204]}, 32'h1);

    // 6: back-to-back frames, start in the cycle after done
    accept(16'h0000, 3'b000);
    run(412, 1'b0, 1'b0, 205, 16'hFFFF, 3'b111);
    check_frame("b2b_f1", 0, 40'hA5_00_00_00_A5);
    check_frame("b2b_f2", 206, 40'hA5_07_FF_FF_A2);
    chk("b2b_done_count", count_done(0, 411), 32'd2);

    // 5: async reset in the middle of byte 2's data bits
    accept(16'h1234, 3'b010);
    repeat (95) step();
    chk("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {29'h0, bus.tx, bus.busy, bus.done}, 32'h4);
    repeat (2) step();
    #2 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.tx !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("no_resume", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
Transmit-side counterpart of the UART command receive path.
- Captures an ALU result and its opcode on a start pulse.
- Frames them into a fixed 5-byte response packet.
- Serializes the packet 8N1, LSB first, on a single TX line.
- Sits after the ALU. It is triggered by the command-ready/ALU-enable strobe and drives the board TX pin back to the host.

Parameters:
- CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200). Must be >= 2.
- HEADER, default 8'hA5, first byte of every response frame.

Ports:
- clock  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to send a frame; sampled only in IDLE
- result  input  16  ALU result, captured on accepted start
- opcode  input  3  opcode of the executed command, captured on accepted start
- tx  output  1  UART serial out, idle high
- busy  output  1  high from the cycle after an accepted start until frame end
- done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (reset low, asynchronous): tx=1, busy=0, done=0, FSM=IDLE, all counters 0, capture registers 0. Takes effect immediately, including mid-frame. tx returns high with no partial stop bit. No frame resumes after reset release.
- Frame bytes, in order:
  - B0 = HEADER
  - B1 = {5'b0, opcode}
  - B2 = result[15:8]
  - B3 = result[7:0]
  - B4 = B0^B1^B2^B3 (XOR checksum, computed at capture)
- Capture: when FSM=IDLE and start=1 at a rising edge, latch result and opcode. busy=1 from the next cycle. Later changes on result/opcode do not affect the frame in flight.
- start while busy=1 is ignored. There is no queuing.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE.
  - IDLE -> START_BIT on accepted start; byte index=0.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA_BITS with bit index=0.
  - DATA_BITS: tx=current byte[bit index] for CLKS_PER_BIT cycles each. LSB first. After bit 7 -> STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte index<4 -> NEXT_BYTE;
    - byte index==4 -> IDLE, with done=1 for one cycle and busy=0 in that same cycle.
  - NEXT_BYTE: one cycle, increment byte index, -> START_BIT. This adds 1 extra idle-high cycle between bytes.
- Latency: tx falls at the edge after start is accepted, i.e. 1 cycle.
- Frame length from accepted start to done: 5*10*CLKS_PER_BIT + 4 cycles, exactly.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- tx is registered: no combinational path from any input to tx.
- start asserted in the same cycle done pulses: FSM is still leaving STOP_BIT, so start is ignored. A new start is accepted the following cycle, in IDLE.

Decomposition:
- Shared package/header uart_pkg holds:
  - FSM state encodings;
  - FRAME_BYTES=5;
  - the default HEADER constant;
  - the default CLKS_PER_BIT.
- One natural sub-module: uart_tx_byte.
  - Bit-level 8N1 serializer with a valid/busy handshake and tx_done pulse.
  - It owns START_BIT/DATA_BITS/STOP_BIT and the bit timer.
  - The top owns capture, checksum, byte indexing and the NEXT_BYTE gap.

Test Plan:
1. Reset and idle: CLKS_PER_BIT=4, hold reset low 3 cycles, release, no start for 50 cycles -> tx=1, busy=0, done=0 throughout.
2. Basic frame: start with result=16'h1234, opcode=3'b010 -> bytes A5, 02, 12, 34, checksum A5^02^12^34=8'h81 decoded from tx, LSB first. done pulses exactly 5*40+4=204 cycles after the accept edge, and busy drops in the same cycle.
3. Input stability: after start, change result to 16'hFFFF and opcode to 3'b111 every cycle -> transmitted frame still A5,02,12,34,81.
4. Start while busy: pulse start at cycles 10, 100 and 203 after accept -> all ignored, one frame only. Start at cycle 205 (IDLE) -> second frame begins; tx falls at the next edge.
5. Reset mid-frame: assert reset during DATA_BITS of B2 -> tx=1 and busy=0 without waiting for a clock edge. After release with no start, the line stays high and no done pulse occurs.
6. Back-to-back frames: result=16'h0000, opcode=0, then result=16'hFFFF, opcode=3'b111 with start in the cycle after done -> frames A5,00,00,00,A5 and A5,07,FF,FF,A2. There is exactly 1 idle-high cycle plus the stop bit between consecutive bytes.
